// File: rtl/qa_7seg_pkg.sv
// Shared types and constants for the 7-segment BCD converter.
// Optional leading-zero blanking is selected with QA_7SEG_LZB_EN.
package qa_7seg_pkg;

  localparam int QA_7SEG_DIGITS = 6;
  localparam int QA_7SEG_BCD_W  = 24;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } qa_7seg_state_e;

  // Digit-pair enables for leading-zero blanking; the lowest pair stays lit so "0" shows.
  function automatic logic [2:0] qa_7seg_lzb(input logic [QA_7SEG_BCD_W-1:0] bcd);
    logic hi;
    logic mid;
    hi  = |bcd[23:16];
    mid = |bcd[15:8];
    return {hi, hi | mid, 1'b1};
  endfunction

endpackage

// File: rtl/qa_7seg_bcd_converter_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module qa_bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/qa_7seg_bcd_converter.sv
// Sequential binary-to-BCD converter with a one-deep pending buffer for a 7-segment driver.
// Define QA_7SEG_LZB_EN to blank leading zero digit pairs via `enable`.
module qa_7seg_bcd_converter
  import qa_7seg_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [IN_WIDTH-1:0]      value,
  output logic [QA_7SEG_BCD_W-1:0] data,
  output logic [2:0]               enable,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  qa_7seg_state_e state_q, state_d;
  logic [IN_WIDTH-1:0]      shift_q, shift_d;
  logic [QA_7SEG_BCD_W-1:0] scratch_q, scratch_d;
  logic [QA_7SEG_BCD_W-1:0] scratch_adj;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic [IN_WIDTH-1:0]      pval_q, pval_d;
  logic [QA_7SEG_BCD_W-1:0] data_q, data_d;
  logic                     done_q, done_d;
  logic                     start;
  logic [IN_WIDTH-1:0]      start_val;

  for (genvar g = 0; g < QA_7SEG_DIGITS; g++) begin : g_adj
    qa_bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

`ifdef QA_7SEG_LZB_EN
  logic [2:0] en_q, en_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pval_d    = pval_q;
    data_d    = data_q;
    done_d    = 1'b0;
    start     = 1'b0;
    start_val = value;
`ifdef QA_7SEG_LZB_EN
    en_d      = en_q;
`endif
    unique case (state_q)
      IDLE: begin
        start = load;
      end
      SHIFT: begin
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = COMMIT;
        if (load) begin
          pend_d = 1'b1;
          pval_d = value;
        end
      end
      COMMIT: begin
        data_d = scratch_q;
        done_d = 1'b1;
`ifdef QA_7SEG_LZB_EN
        en_d   = qa_7seg_lzb(scratch_q);
`endif
        // A load on this very cycle is newer than anything pending, so it wins.
        if (load) begin
          start = 1'b1;
        end else if (pend_q) begin
          start     = 1'b1;
          start_val = pval_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      shift_d   = start_val;
      scratch_d = '0;
      cnt_d     = CW'(IN_WIDTH);
      pend_d    = 1'b0;
      state_d   = SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pval_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pval_q    <= pval_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

`ifdef QA_7SEG_LZB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 3'b001;
    else     en_q <= en_d;
  end
  assign enable = en_q;
`else
  assign enable = 3'b111;
`endif

  assign data = data_q;
  assign done = done_q;
  assign busy = (state_q != IDLE) || pend_q;

endmodule
